// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, owners, IO region and access sizes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StResp  = 2'd3
    } state_e;

    typedef enum logic {
        OwnIf  = 1'b0,
        OwnLsb = 1'b1
    } owner_e;

    // addr[17:16] value that selects the UART / IO window
    localparam logic [1:0] IoRegion = 2'b11;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    // Byte count of an LSB access; the illegal size 3 is handled as a word.
    function automatic logic [4:0] ls_len(input logic [1:0] size);
        case (size)
            SizeByte: return 5'd1;
            SizeHalf: return 5'd2;
            default:  return 5'd4;
        endcase
    endfunction

    function automatic logic is_io(input logic [1:0] addr_17_16);
        return addr_17_16 == IoRegion;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter between the instruction fetcher and the load/store buffer.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned IF_BYTES = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_clear_up,
    input  logic                  io_buffer_full,
    output logic                  mem_wr,
    output logic [31:0]           mem_a,
    output logic [7:0]            mem_dout,
    input  logic [7:0]            mem_din,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_done,
    output logic [8*IF_BYTES-1:0] if_data,
    input  logic                  ls_req,
    input  logic                  ls_wr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_addr,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata
);

    localparam int unsigned DataW = 8 * IF_BYTES;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    owner_e             last_q, last_d;
    logic [31:0]        addr_q, addr_d;
    logic [4:0]         len_q, len_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               wr_q, wr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [DataW-1:0]   data_q, data_d;

    logic [31:0] byte_addr;
    logic        issue_rd;
    logic        io_stall;
    logic        issue_wr;
    logic [7:0]  wr_byte;
    owner_e      pick;

    // Per-byte issue decode shared by next-state and output logic
    always_comb begin
        byte_addr = addr_q + 32'(cnt_q);
        issue_rd  = (state_q == StRead) && (cnt_q < len_q);
        io_stall  = (state_q == StWrite) && is_io(byte_addr[17:16]) && io_buffer_full;
        issue_wr  = (state_q == StWrite) && !io_stall;
        case (cnt_q[1:0])
            2'd0:    wr_byte = wdata_q[7:0];
            2'd1:    wr_byte = wdata_q[15:8];
            2'd2:    wr_byte = wdata_q[23:16];
            default: wr_byte = wdata_q[31:24];
        endcase
        // Round-robin only matters when both sides ask at once
        if (if_req && ls_req) begin
            pick = (last_q == OwnLsb) ? OwnIf : OwnLsb;
        end else begin
            pick = if_req ? OwnIf : OwnLsb;
        end
    end

    // Next-state: grant, byte sequencing, flush handling; everything holds while rdy_in is low
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        if (rdy_in) begin
            case (state_q)
                StIdle: begin
                    if (!rob_clear_up && (if_req || ls_req)) begin
                        owner_d = pick;
                        last_d  = pick;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                        data_d  = '0;
                        if (pick == OwnIf) begin
                            addr_d  = if_addr & ~(32'(IF_BYTES) - 32'd1);
                            len_d   = 5'(IF_BYTES);
                            wr_d    = 1'b0;
                            state_d = StRead;
                        end else begin
                            addr_d  = ls_addr;
                            len_d   = ls_len(ls_size);
                            wr_d    = ls_wr;
                            wdata_d = ls_wdata;
                            state_d = ls_wr ? StWrite : StRead;
                        end
                    end
                end
                StRead: begin
                    if (rob_clear_up) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                        data_d  = '0;
                    end else begin
                        // pend_q: the byte issued last cycle (index cnt_q-1) is on mem_din now
                        for (int i = 0; i < IF_BYTES; i++) begin
                            if (pend_q && (cnt_q == 5'(i + 1))) begin
                                data_d[8*i +: 8] = mem_din;
                            end
                        end
                        pend_d = issue_rd;
                        if (issue_rd) begin
                            cnt_d = cnt_q + 5'd1;
                        end else begin
                            state_d = StResp;
                        end
                    end
                end
                StWrite: begin
                    // Stores are not cancelled by a flush: they are already committed
                    if (issue_wr) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q + 5'd1 == len_q) begin
                            state_d = StResp;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            owner_q <= OwnIf;
            last_q  <= OwnLsb;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    // RAM port drive; zero whenever no byte is being issued
    always_comb begin
        mem_wr   = 1'b0;
        mem_a    = '0;
        mem_dout = '0;
        if (issue_wr && rdy_in) begin
            mem_wr   = 1'b1;
            mem_a    = byte_addr;
            mem_dout = wr_byte;
        end else if (state_q == StRead) begin
            if (rdy_in && issue_rd) begin
                mem_a = byte_addr;
            end else if (!rdy_in && pend_q) begin
                // Keep re-presenting the in-flight byte so mem_din is still its data on resume
                mem_a = byte_addr - 32'd1;
            end
        end
    end

    // Done pulses: held off while frozen, suppressed by a flush for reads only
    always_comb begin
        if_done  = (state_q == StResp) && rdy_in && (owner_q == OwnIf) && !rob_clear_up;
        ls_done  = (state_q == StResp) && rdy_in && (owner_q == OwnLsb) &&
                   (wr_q || !rob_clear_up);
        if_data  = data_q;
        ls_rdata = data_q[31:0];
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, scoreboard-checked bench for mem_arbiter with a one-cycle-latency RAM model.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear_up;
    logic        io_buffer_full;
    logic        mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'h00;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    typedef struct packed {
        logic        is_if;
        logic [31:0] data;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];
    logic [7:0] ram [logic [31:0]];

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.IF_BYTES(4)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .rob_clear_up   (rob_clear_up),
        .io_buffer_full (io_buffer_full),
        .mem_wr         (mem_wr),
        .mem_a          (mem_a),
        .mem_dout       (mem_dout),
        .mem_din        (mem_din),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_done        (if_done),
        .if_data        (if_data),
        .ls_req         (ls_req),
        .ls_wr          (ls_wr),
        .ls_size        (ls_size),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // RAM read data is valid the cycle after the address
    always @(posedge clk_in) mem_din <= ram_rd(mem_a);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response scoreboard
    always @(negedge clk_in) begin
        if (if_done || ls_done) begin
            chk("resp_expected", 64'(rq.size() != 0), 64'd1);
            if (rq.size() != 0) begin
                resp_t e;
                e = rq.pop_front();
                chk("resp_owner", {62'd0, if_done, ls_done}, e.is_if ? 64'd2 : 64'd1);
                chk("resp_data", 64'(e.is_if ? if_data : ls_rdata), 64'(e.data));
            end
        end
    end

    // Write scoreboard
    always @(negedge clk_in) begin
        if (mem_wr) begin
            chk("wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                wr_t w;
                w = wq.pop_front();
                chk("wr_addr_data", {24'd0, mem_a, mem_dout}, {24'd0, w.addr, w.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic drive_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_done(input logic want_if, input string tag);
        int k = 0;
        @(negedge clk_in);
        while (!(want_if ? if_done : ls_done) && k < 40) begin
            @(negedge clk_in);
            k++;
        end
        chk(tag, 64'(want_if ? if_done : ls_done), 64'd1);
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_clear_up = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0;
        ls_addr = '0; ls_wdata = '0;
        ram[32'h100] = 8'h01; ram[32'h101] = 8'h02; ram[32'h102] = 8'h03; ram[32'h103] = 8'h04;
        ram[32'h104] = 8'h13; ram[32'h105] = 8'h05; ram[32'h106] = 8'h00; ram[32'h107] = 8'h00;
        ram[32'h108] = 8'haa; ram[32'h109] = 8'hbb; ram[32'h10a] = 8'hcc; ram[32'h10b] = 8'hdd;
        ram[32'h301] = 8'h34; ram[32'h302] = 8'h82;

        // Reset values
        cyc(); cyc();
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_mem_a", 64'(mem_a), 64'd0);
        chk("rst_mem_dout", 64'(mem_dout), 64'd0);
        chk("rst_dones", {62'd0, if_done, ls_done}, 64'd0);
        chk("rst_data", {if_data, ls_rdata}, 64'd0);
        drive_edge();
        rst_in = 1'b0;
        cyc();

        // Instruction fetch @0x104
        drive_edge();
        if_req = 1'b1; if_addr = 32'h104;
        rq.push_back('{is_if: 1'b1, data: 32'h0000_0513});
        cyc();
        chk("if_c0_mem_a", 64'(mem_a), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("if_mem_a", 64'(mem_a), 64'(32'h104 + i));
        end
        cyc();
        chk("if_c5_no_done", {62'd0, if_done, ls_done}, 64'd0);
        cyc();
        chk("if_c6_done", 64'(if_done), 64'd1);
        drive_edge();
        if_req = 1'b0;

        // Store word 0xDEADBEEF @0x200
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h200; ls_wdata = 32'hdead_beef;
        wq.push_back('{addr: 32'h200, data: 8'hef});
        wq.push_back('{addr: 32'h201, data: 8'hbe});
        wq.push_back('{addr: 32'h202, data: 8'had});
        wq.push_back('{addr: 32'h203, data: 8'hde});
        rq.push_back('{is_if: 1'b0, data: 32'h0});
        cyc();
        chk("st_c0_wr", 64'(mem_wr), 64'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("st_mem_wr", 64'(mem_wr), 64'd1);
        end
        cyc();
        chk("st_c5_done", 64'(ls_done), 64'd1);
        drive_edge();
        ls_req = 1'b0;

        // Contested grants alternate IF, LSB, IF, LSB
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd2; ls_addr = 32'h104;
        rq.push_back('{is_if: 1'b1, data: 32'h0403_0201});
        cyc(); cyc();
        chk("rr_first_if", 64'(mem_a), 64'h100);
        wait_done(1'b1, "rr_if1_done");
        drive_edge();
        if_addr = 32'h108;
        rq.push_back('{is_if: 1'b0, data: 32'h0000_0513});
        rq.push_back('{is_if: 1'b1, data: 32'hddcc_bbaa});
        cyc(); cyc();
        chk("rr_then_lsb", 64'(mem_a), 64'h104);
        wait_done(1'b0, "rr_ls1_done");
        drive_edge();
        ls_size = 2'd0; ls_addr = 32'h100;
        rq.push_back('{is_if: 1'b0, data: 32'h0000_0001});
        cyc(); cyc();
        chk("rr_then_if", 64'(mem_a), 64'h108);
        wait_done(1'b1, "rr_if2_done");
        drive_edge();
        if_req = 1'b0;
        wait_done(1'b0, "rr_ls2_done");
        drive_edge();
        ls_req = 1'b0;

        // Load half @0x301 flushed in cycle 2
        ls_req = 1'b1; ls_wr = 1'b0; ls_size = 2'd1; ls_addr = 32'h301;
        cyc(); cyc();
        chk("fl_c1_mem_a", 64'(mem_a), 64'h301);
        drive_edge();
        rob_clear_up = 1'b1;
        cyc();
        chk("fl_c2_no_done", {62'd0, if_done, ls_done}, 64'd0);
        drive_edge();
        rob_clear_up = 1'b0; ls_req = 1'b0;
        cyc();
        chk("fl_c3_idle_a", 64'(mem_a), 64'd0);
        chk("fl_c3_rdata_clr", 64'(ls_rdata), 64'd0);
        cyc();
        chk("fl_c4_no_done", {62'd0, if_done, ls_done}, 64'd0);
        drive_edge();
        if_req = 1'b1; if_addr = 32'h104;
        rq.push_back('{is_if: 1'b1, data: 32'h0000_0513});
        cyc(); cyc();
        chk("fl_after_if_a", 64'(mem_a), 64'h104);
        wait_done(1'b1, "fl_after_if_done");
        drive_edge();
        if_req = 1'b0;

        // IO-stalled byte store @0x30000, flush in cycle 2 does not cancel it
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd0; ls_addr = 32'h3_0000; ls_wdata = 32'h41;
        wq.push_back('{addr: 32'h3_0000, data: 8'h41});
        rq.push_back('{is_if: 1'b0, data: 32'h0});
        cyc();
        drive_edge();
        io_buffer_full = 1'b1;
        cyc();
        chk("io_c1_stall", {31'd0, mem_wr, mem_a}, 64'd0);
        drive_edge();
        rob_clear_up = 1'b1;
        cyc();
        chk("io_c2_stall", 64'(mem_wr), 64'd0);
        drive_edge();
        rob_clear_up = 1'b0;
        cyc();
        chk("io_c3_stall", 64'(mem_wr), 64'd0);
        drive_edge();
        io_buffer_full = 1'b0;
        cyc();
        chk("io_c4_write", {31'd0, mem_wr, mem_a}, {31'd0, 1'b1, 32'h3_0000});
        cyc();
        chk("io_c5_done", 64'(ls_done), 64'd1);
        drive_edge();
        ls_req = 1'b0;

        // Freeze for three cycles mid-read
        if_req = 1'b1; if_addr = 32'h100;
        rq.push_back('{is_if: 1'b1, data: 32'h0403_0201});
        cyc(); cyc();
        chk("frz_c1_a", 64'(mem_a), 64'h100);
        cyc();
        chk("frz_c2_a", 64'(mem_a), 64'h101);
        for (int i = 0; i < 3; i++) begin
            drive_edge();
            rdy_in = 1'b0;
            cyc();
            chk("frz_hold", {62'd0, mem_wr, if_done}, 64'd0);
        end
        drive_edge();
        rdy_in = 1'b1;
        cyc();
        chk("frz_resume_a", 64'(mem_a), 64'h102);
        cyc();
        chk("frz_resume_a2", 64'(mem_a), 64'h103);
        wait_done(1'b1, "frz_done");
        drive_edge();
        if_req = 1'b0;

        // Reset in the middle of a word store
        ls_req = 1'b1; ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h400; ls_wdata = 32'h1122_3344;
        wq.push_back('{addr: 32'h400, data: 8'h44});
        wq.push_back('{addr: 32'h401, data: 8'h33});
        cyc(); cyc();
        chk("rstw_c1_wr", 64'(mem_wr), 64'd1);
        cyc();
        chk("rstw_c2_dout", 64'(mem_dout), 64'h33);
        #2;
        rst_in = 1'b1; ls_req = 1'b0;
        #1;
        chk("rstw_async_wr", {31'd0, mem_wr, mem_a}, 64'd0);
        drive_edge();
        rst_in = 1'b0;
        cyc();
        chk("rstw_idle", {30'd0, mem_wr, if_done, ls_done, mem_a}, 64'd0);
        drive_edge();
        if_req = 1'b1; if_addr = 32'h107;
        rq.push_back('{is_if: 1'b1, data: 32'h0000_0513});
        cyc(); cyc();
        chk("rstw_if_aligned_a", 64'(mem_a), 64'h104);
        wait_done(1'b1, "rstw_if_done");
        drive_edge();
        if_req = 1'b0;
        cyc(); cyc();

        chk("resp_queue_drained", 64'(rq.size()), 64'd0);
        chk("wr_queue_drained", 64'(wq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between the instruction fetcher and the load/store buffer (LSB).
- Picks one requester at a time and latches its request.
- Sequences the multi-byte access one byte per cycle, then returns assembled read data or a write-complete pulse.
- Honours ROB flush, the global ready stall and the IO-buffer-full stall.

Parameters:
IF_BYTES, 4, bytes per instruction-fetch transfer (power of two, 4..16); fetch data width is 8*IF_BYTES.

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global ready; low freezes the block
rob_clear_up  in  1  pipeline flush
io_buffer_full  in  1  UART output buffer full
mem_wr  out  1  RAM write enable (1 = write)
mem_a  out  32  RAM byte address
mem_dout  out  8  RAM write data
mem_din  in  8  RAM read data, valid the cycle after mem_a
if_req  in  1  fetch request, held until if_done
if_addr  in  32  fetch address; low log2(IF_BYTES) bits forced to 0
if_done  out  1  one-cycle pulse: if_data valid
if_data  out  8*IF_BYTES  little-endian fetched bytes
ls_req  in  1  LSB request, held until ls_done
ls_wr  in  1  1 = store
ls_size  in  2  0 = byte, 1 = half, 2 = word (3 is illegal and treated as word)
ls_addr  in  32  byte address; misaligned accesses are allowed
ls_wdata  in  32  store data, little-endian
ls_done  out  1  one-cycle pulse: access finished
ls_rdata  out  32  load data, zero-extended (the LSB does sign extension)

Behaviour:
- Reset values: all outputs 0; state IDLE; byte counter 0; last_grant = LSB, so the first contested grant goes to IF.
- Freeze (rdy_in = 0):
  - All registers hold and mem_wr is forced to 0.
  - Any pending done pulse is delayed until rdy_in returns.
- States:
  - IDLE: no transfer active.
  - READ: byte-serial read for IF or a load.
  - WRITE: byte-serial store.
  - RESP: one cycle that drives the done pulse.
- Grant (IDLE, cycle 0):
  - If only one request is asserted, grant it.
  - If both are asserted, grant the side not in last_grant (round-robin), then update last_grant.
  - On grant, latch owner, address, length N (IF_BYTES, or 1/2/4 for LSB), write flag and wdata; clear the counter.
- Read sequence:
  - mem_a = base + i in cycle 1+i, for i = 0..N-1.
  - Byte i is captured from mem_din at the end of cycle 2+i.
  - RESP occurs in cycle N+2, with done high and the data register complete.
  - Unwritten upper bytes of ls_rdata are 0.
- Write sequence:
  - In cycle 1+i: mem_wr = 1, mem_a = base + i, mem_dout = wdata byte i.
  - RESP occurs in cycle N+1 with ls_done high.
- IO stall on writes:
  - Applies when the address satisfies addr[17:16] == 2'b11 and io_buffer_full = 1.
  - mem_wr = 0, the counter does not advance, and the same byte is retried next cycle.
- Idle outputs: mem_a, mem_dout and mem_wr are 0 whenever no byte is being issued (IDLE, RESP, stalled).
- Returning from RESP:
  - RESP returns to IDLE at the next edge.
  - The requester drops req at that same edge, so no re-grant of a stale request can occur.
- Flush (rob_clear_up = 1 at an edge):
  - In READ: abort, go to IDLE, no done pulse, data register cleared.
  - In WRITE: continue; the store completes and ls_done still pulses.
  - In IDLE: requests sampled in that cycle are not granted.
  - In RESP for a read: the pulse is suppressed. This means the done output is gated by !rob_clear_up for reads.
- Address arithmetic: mod 2^32; a wrap at 0xFFFFFFFF is allowed with no error.
- Reset mid-transfer: immediate return to reset values, including mem_wr = 0 asynchronously.

Decomposition:
- Shared include Const.v gets:
  - state encodings: IDLE / READ / WRITE / RESP;
  - owner encodings: IF / LSB;
  - IO region constant 2'b11 on addr[17:16];
  - ls_size encodings.
- No sub-module is required. An optional byte-lane assembler (mem_byte_packer) packs byte i into position 8i; it is combinational only and shared by the IF and LSB data paths.

Test Plan:
- if_req with if_addr = 0x104, RAM bytes 13 05 00 00 -> mem_a = 0x104..0x107 in cycles 1-4; if_done in cycle 6 with if_data = 0x00000513.
- ls_req store word 0xDEADBEEF @0x200 -> mem_wr = 1 with dout EF, BE, AD, DE at 0x200..0x203 in cycles 1-4; ls_done in cycle 5.
- if_req and ls_req asserted together twice in succession -> grants alternate IF then LSB then IF; neither side is starved.
- Load half @0x301 (RAM 0x34, 0x82) with rob_clear_up pulsed in cycle 2 -> no ls_done; IDLE next cycle; a subsequent if_req is granted normally.
- Store byte 0x41 @0x30000 with io_buffer_full high for cycles 1-3 -> mem_wr = 0 during those cycles; write happens in cycle 4; ls_done in cycle 5. A flush in cycle 2 does not cancel it.
- rdy_in low for 3 cycles mid-read, plus rst_in pulsed mid-write -> read resumes at the same byte index with correct data; after the reset, mem_wr = 0 immediately and the block is in IDLE.
